// File: rtl/uart_tx_frame.sv
// uart_tx_frame: valid/ready UART transmitter; start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (even, or odd when PARITY_ODD=1).
module uart_tx_frame #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
    localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned IDX_W    = $clog2(DATA_BITS + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_frame: CLK_HZ/BAUD must be at least 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 tx_n, ready_n;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_n;
`endif

    assign bit_end = (cnt == CNT_W'(BAUD_DIV - 1));
    assign tx_busy = ~tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shift    <= shift_n;
            tx       <= tx_n;
            tx_ready <= ready_n;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    // tx is registered, so each bit value is loaded on the boundary edge that starts it
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        idx_n   = idx;
        shift_n = shift;
        tx_n    = tx;
        ready_n = tx_ready;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            S_IDLE: begin
                cnt_n   = '0;
                idx_n   = '0;
                tx_n    = 1'b1;
                ready_n = 1'b1;
                if (tx_valid && tx_ready) begin
                    shift_n = tx_data;
                    state_n = S_START;
                    tx_n    = 1'b0;
                    ready_n = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_n   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    tx_n    = shift[0];
                    shift_n = shift >> 1;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_n   = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
                        tx_n    = par;
`else
                        state_n = S_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        tx_n    = shift[0];
                        shift_n = shift >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    tx_n    = 1'b1;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == IDX_W'(STOP_BITS - 1)) begin
                        idx_n   = '0;
                        state_n = S_IDLE;
                        ready_n = 1'b1;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                idx_n   = '0;
                tx_n    = 1'b1;
                ready_n = 1'b1;
            end
        endcase
    end

endmodule
